// File: rtl/wb_csr_pkg.sv
// rtl/wb_csr_pkg.sv - shared types and helpers for the Wishbone CSR bank
package wb_csr_pkg;

   localparam int DATA_W = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   // Word index of the interrupt status register (directly after the RO block)
   function automatic int irq_status_idx(input int n_rw, input int n_ro);
      return n_rw + n_ro;
   endfunction

   // Word index of the interrupt enable register
   function automatic int irq_enable_idx(input int n_rw, input int n_ro);
      return n_rw + n_ro + 1;
   endfunction

   // Expand four byte-lane selects into a 32-bit bit mask
   function automatic logic [DATA_W-1:0] sel_mask(input logic [3:0] sel);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int k = 0; k < 4; k++) begin
         m[8*k +: 8] = {8{sel[k]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/wb_csr_irq.sv
// rtl/wb_csr_irq.sv - interrupt status/enable registers and level irq output
module wb_csr_irq #(
   parameter int N_IRQ = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_status,
   input  logic             wr_enable,
   input  logic [N_IRQ-1:0] wdata,
   input  logic [N_IRQ-1:0] wmask,
   input  logic [N_IRQ-1:0] irq_event,
   output logic [N_IRQ-1:0] status,
   output logic [N_IRQ-1:0] enable,
   output logic             irq
);

   // Status is W1C with events winning; enable is byte-masked RW; irq lags state by one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         status <= '0;
         enable <= '0;
         irq    <= 1'b0;
      end else begin
         if (wr_status) begin
            status <= (status & ~(wdata & wmask)) | irq_event;
         end else begin
            status <= status | irq_event;
         end
         if (wr_enable) begin
            enable <= (enable & ~wmask) | (wdata & wmask);
         end
         irq <= |(status & enable);
      end
   end

endmodule

// File: rtl/wb_csr_bank.sv
// rtl/wb_csr_bank.sv - Wishbone B4 classic slave with RW, RO and interrupt registers
module wb_csr_bank
   import wb_csr_pkg::*;
#(
   parameter logic [31:0]         BASE_ADDR = 32'h3000_0000,
   parameter int                  N_RW      = 6,
   parameter int                  N_RO      = 4,
   parameter int                  N_IRQ     = 8,
   parameter logic [N_RW*32-1:0]  RW_RESET  = '0
) (
   input  logic                                wb_clk_i,
   input  logic                                wb_rst_i,
   input  logic                                wbs_stb_i,
   input  logic                                wbs_cyc_i,
   input  logic                                wbs_we_i,
   input  logic [3:0]                          wbs_sel_i,
   input  logic [31:0]                         wbs_adr_i,
   input  logic [31:0]                         wbs_dat_i,
   output logic                                wbs_ack_o,
   output logic                                wbs_err_o,
   output logic [31:0]                         wbs_dat_o,
   output logic [N_RW*32-1:0]                  rw_regs_o,
   output logic [N_RW-1:0]                     rw_wr_o,
   input  logic [(N_RO > 0 ? N_RO : 1)*32-1:0] ro_regs_i,
   input  logic [N_IRQ-1:0]                    irq_event_i,
   output logic                                irq_o
);

   localparam logic [29:0] IDX_RO_END = 30'(N_RW + N_RO);
   localparam logic [29:0] IDX_STAT   = 30'(irq_status_idx(N_RW, N_RO));
   localparam logic [29:0] IDX_EN     = 30'(irq_enable_idx(N_RW, N_RO));

   state_t              state_q, state_d;
   logic                accept;
   logic                below;
   logic [29:0]         idx;
   logic                hit_rw, hit_ro, hit_stat, hit_en, mapped;
   logic [DATA_W-1:0]   wmask;
   logic [DATA_W-1:0]   rd_data;
   logic [N_IRQ-1:0]    irq_status, irq_enable;
   logic                unused_adr_lsb;

   assign unused_adr_lsb = ^wbs_adr_i[1:0];

   assign accept   = (state_q == ST_IDLE) && wbs_stb_i && wbs_cyc_i;
   assign below    = wbs_adr_i < BASE_ADDR;
   assign idx      = wbs_adr_i[31:2] - BASE_ADDR[31:2];
   assign hit_rw   = !below && (idx < 30'(N_RW));
   assign hit_ro   = !below && (idx >= 30'(N_RW)) && (idx < IDX_RO_END);
   assign hit_stat = !below && (idx == IDX_STAT);
   assign hit_en   = !below && (idx == IDX_EN);
   assign mapped   = hit_rw || hit_ro || hit_stat || hit_en;
   assign wmask    = sel_mask(wbs_sel_i);

   // Read mux over the addressed word; RO inputs are sampled at acceptance
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < N_RW; i++) begin
         if (hit_rw && idx == 30'(i)) rd_data = rw_regs_o[32*i +: 32];
      end
      for (int j = 0; j < N_RO; j++) begin
         if (hit_ro && idx == 30'(N_RW + j)) rd_data = ro_regs_i[32*j +: 32];
      end
      if (hit_stat) rd_data[N_IRQ-1:0] = irq_status;
      if (hit_en)   rd_data[N_IRQ-1:0] = irq_enable;
   end

   // Next state: accept in IDLE, always leave RESP after one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Response outputs are high only during the RESP cycle following acceptance
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_err_o <= 1'b0;
         wbs_dat_o <= '0;
         rw_wr_o   <= '0;
      end else begin
         wbs_ack_o <= accept && mapped;
         wbs_err_o <= accept && !mapped;
         wbs_dat_o <= (accept && mapped && !wbs_we_i) ? rd_data : '0;
         for (int i = 0; i < N_RW; i++) begin
            rw_wr_o[i] <= accept && wbs_we_i && hit_rw && (idx == 30'(i));
         end
      end
   end

   // RW word storage with byte-lane write masking
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rw_regs_o <= RW_RESET;
      end else begin
         for (int i = 0; i < N_RW; i++) begin
            if (accept && wbs_we_i && hit_rw && (idx == 30'(i))) begin
               rw_regs_o[32*i +: 32] <= (rw_regs_o[32*i +: 32] & ~wmask) | (wbs_dat_i & wmask);
            end
         end
      end
   end

   wb_csr_irq #(
      .N_IRQ(N_IRQ)
   ) u_irq (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .wr_status (accept && wbs_we_i && hit_stat),
      .wr_enable (accept && wbs_we_i && hit_en),
      .wdata     (wbs_dat_i[N_IRQ-1:0]),
      .wmask     (wmask[N_IRQ-1:0]),
      .irq_event (irq_event_i),
      .status    (irq_status),
      .enable    (irq_enable),
      .irq       (irq_o)
   );

endmodule

// File: doc/wb_csr_bank.md
# wb_csr_bank

Parametrised Wishbone B4 classic slave that replaces fixed-address CSR decoding with a generated register bank: N_RW read/write words, N_RO read-only status words, and a write-1-to-clear interrupt block. It honours byte selects, flags unmapped accesses with `wbs_err_o`, and drives a level interrupt. It sits between the Caravel Wishbone bus and the MAC/IP/UDP offload datapath (addresses, ports, offload control out; captured source fields and counters in).

## Interface
Parameters:
- `BASE_ADDR`, 32'h3000_0000, word-aligned base of the bank
- `N_RW`, 6, number of 32-bit RW registers (1..64)
- `N_RO`, 4, number of 32-bit RO registers (0..64)
- `N_IRQ`, 8, interrupt sources (1..32)
- `RW_RESET`, all zero, `N_RW*32`-bit flattened reset values; word i at bits [32*i+31:32*i]

Ports (one clock; reset is synchronous and active-high):
- `wb_clk_i` in 1 clock
- `wb_rst_i` in 1 synchronous active-high reset
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each, Wishbone strobe/cycle/write
- `wbs_sel_i` in 4 byte lane selects
- `wbs_adr_i` in 32 byte address
- `wbs_dat_i` in 32 write data
- `wbs_ack_o` out 1 transfer acknowledge
- `wbs_err_o` out 1 transfer error (unmapped)
- `wbs_dat_o` out 32 read data
- `rw_regs_o` out N_RW*32 flattened RW register contents
- `rw_wr_o` out N_RW one-cycle pulse per RW word written
- `ro_regs_i` in N_RO*32 flattened RO status inputs (max(N_RO,1)*32 wide)
- `irq_event_i` in N_IRQ one-cycle event pulses
- `irq_o` out 1 interrupt request

## Operation
- Word index `idx = (wbs_adr_i - BASE_ADDR) >> 2`; `wbs_adr_i[1:0]` ignored. Map: idx 0..N_RW-1 RW; N_RW..N_RW+N_RO-1 RO; N_RW+N_RO = IRQ_STATUS; N_RW+N_RO+1 = IRQ_ENABLE; anything else (including addresses below BASE_ADDR) unmapped.
- FSM states: IDLE, RESP.
  - IDLE: if `stb&cyc`, latch addr/data/sel/we, perform the access, go to RESP. Else stay.
  - RESP: `ack_o` or `err_o` high for exactly this cycle; always return to IDLE. No new transfer is accepted in RESP.
- RW write: only byte lanes with `sel[k]=1` update; `rw_wr_o[idx]` pulses in the RESP cycle.
- RO write: data discarded, ack (no error). IRQ_STATUS write: bits set in data (under sel) cleared (W1C). IRQ_ENABLE write: byte-masked RW. Bits ≥ N_IRQ read 0 and are not writable.
- Reads: `wbs_dat_o` valid in RESP cycle, full 32 bits regardless of sel; RO value sampled in the IDLE acceptance cycle.
- Unmapped read/write: `wbs_err_o`=1, `wbs_ack_o`=0, no state change, `wbs_dat_o`=0.
- `irq_event_i[b]` sets status[b]. Same cycle as a W1C clear of that bit: set wins.
- `irq_o` registered: `|(status & enable)` from the previous cycle's state.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_err_o`=0, `wbs_dat_o`=0, `rw_regs_o`=RW_RESET, `rw_wr_o`=0, status=0, enable=0, `irq_o`=0, FSM=IDLE.
- Latency: request seen at edge n → ack/err high after edge n+1, low after n+2. Throughput: one transfer per 2 cycles. RW value visible on `rw_regs_o` together with ack.
- Master dropping `stb` during RESP: response still completes; no effect.
- Reset asserted mid-transfer: pending response dropped, all state to reset values next edge.
- Event to `irq_o`: 2 cycles when enabled.

## Structure
- Package `wb_csr_pkg`: FSM state encoding, IRQ_STATUS/IRQ_ENABLE offset functions of N_RW/N_RO, data width 32.
- Sub-module `wb_csr_irq`: status/enable registers, W1C/set priority, `irq_o` register.

## Test plan
- Reset, read idx 0 with RW_RESET word 0 = 32'h0000_00fb → ack after 2 cycles, dat=32'h0000_00fb, err=0.
- Write 32'hAABBCCDD to idx 1 with sel=4'b0101 over 32'h11223344 → reads 32'h11BB33DD, `rw_wr_o[1]` one pulse.
- Read RO idx N_RW with `ro_regs_i` word 0 = 32'hDEAD_BEEF → dat=32'hDEAD_BEEF; write to it → ack, value unchanged.
- Access BASE_ADDR+4*(N_RW+N_RO+2) and BASE_ADDR-4 → err=1, ack=0, dat=0, no register change.
- Enable=8'h05, pulse event[2] → `irq_o`=1 two cycles later; W1C 32'h4 coincident with new event[2] → status bit stays 1; W1C alone → `irq_o` 0.
- Back-to-back writes with stb held high → each acked once, 2-cycle spacing; reset mid-RESP → no ack, registers at RW_RESET.
